// File: rtl/l2_arbiter.sv
// Two-client (I-cache read, D-cache read/write) arbiter in front of the L2 cache.
// Define L2ARB_RR_EN for round-robin tie breaking; otherwise the D-cache always wins a tie.
//
// state   | meaning
// IDLE    | sample client requests, latch the winner into the L2 request registers
// BUSY    | L2 request held; waiting for l2arb_mem_resp
// RELEASE | dead cycle so the L1 can drop a satisfied request and L2 can go idle
module l2_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              icache_pmem_read,
    input  logic [ADDR_W-1:0] icache_pmem_address,
    output logic [LINE_W-1:0] icache_pmem_rdata,
    output logic              icache_pmem_resp,
    input  logic              dcache_pmem_read,
    input  logic              dcache_pmem_write,
    input  logic [ADDR_W-1:0] dcache_pmem_address,
    input  logic [LINE_W-1:0] dcache_pmem_wdata,
    output logic [LINE_W-1:0] dcache_pmem_rdata,
    output logic              dcache_pmem_resp,
    output logic              l2arb_mem_read,
    output logic              l2arb_mem_write,
    output logic [ADDR_W-1:0] l2arb_mem_address,
    output logic [LINE_W-1:0] l2arb_mem_wdata,
    input  logic [LINE_W-1:0] l2arb_mem_rdata,
    input  logic              l2arb_mem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              grant_d, grant_d_nxt;
    logic              read_nxt, write_nxt;
    logic [ADDR_W-1:0] address_nxt;
    logic [LINE_W-1:0] wdata_nxt;
    logic              i_req, d_req, pick_d, done;

    assign i_req = icache_pmem_read;
    assign d_req = dcache_pmem_read | dcache_pmem_write;
    assign done  = (state == BUSY) & l2arb_mem_resp;

`ifdef L2ARB_RR_EN
    // last_grant: 1 = D-cache completed the most recent transaction
    logic last_grant;

    assign pick_d = d_req & (~i_req | ~last_grant);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b0;
        end else if (done) begin
            last_grant <= grant_d;
        end
    end
`else
    assign pick_d = d_req;
`endif

    always_comb begin
        state_nxt   = state;
        grant_d_nxt = grant_d;
        read_nxt    = l2arb_mem_read;
        write_nxt   = l2arb_mem_write;
        address_nxt = l2arb_mem_address;
        wdata_nxt   = l2arb_mem_wdata;
        case (state)
            IDLE: begin
                if (i_req | d_req) begin
                    state_nxt   = BUSY;
                    grant_d_nxt = pick_d;
                    if (pick_d) begin
                        // read+write together is treated as a write
                        write_nxt   = dcache_pmem_write;
                        read_nxt    = ~dcache_pmem_write;
                        address_nxt = dcache_pmem_address;
                        wdata_nxt   = dcache_pmem_write ? dcache_pmem_wdata : '0;
                    end else begin
                        write_nxt   = 1'b0;
                        read_nxt    = 1'b1;
                        address_nxt = icache_pmem_address;
                        wdata_nxt   = '0;
                    end
                end
            end
            BUSY: begin
                if (l2arb_mem_resp) begin
                    state_nxt = RELEASE;
                    read_nxt  = 1'b0;
                    write_nxt = 1'b0;
                end
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            grant_d           <= 1'b1;
            l2arb_mem_read    <= 1'b0;
            l2arb_mem_write   <= 1'b0;
            l2arb_mem_address <= '0;
            l2arb_mem_wdata   <= '0;
        end else begin
            state             <= state_nxt;
            grant_d           <= grant_d_nxt;
            l2arb_mem_read    <= read_nxt;
            l2arb_mem_write   <= write_nxt;
            l2arb_mem_address <= address_nxt;
            l2arb_mem_wdata   <= wdata_nxt;
        end
    end

    assign icache_pmem_resp  = done & ~grant_d;
    assign dcache_pmem_resp  = done & grant_d;
    assign icache_pmem_rdata = l2arb_mem_rdata;
    assign dcache_pmem_rdata = l2arb_mem_rdata;

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: scoreboard of expected L2 transactions, popped as the
// DUT presents each request to the modelled L2. Honours L2ARB_RR_EN for the tie-order scenario.
module tb_l2_arbiter;
    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;

    logic              clk = 1'b0;
    logic              reset;
    logic              icache_pmem_read;
    logic [ADDR_W-1:0] icache_pmem_address;
    logic [LINE_W-1:0] icache_pmem_rdata;
    logic              icache_pmem_resp;
    logic              dcache_pmem_read;
    logic              dcache_pmem_write;
    logic [ADDR_W-1:0] dcache_pmem_address;
    logic [LINE_W-1:0] dcache_pmem_wdata;
    logic [LINE_W-1:0] dcache_pmem_rdata;
    logic              dcache_pmem_resp;
    logic              l2arb_mem_read;
    logic              l2arb_mem_write;
    logic [ADDR_W-1:0] l2arb_mem_address;
    logic [LINE_W-1:0] l2arb_mem_wdata;
    logic [LINE_W-1:0] l2arb_mem_rdata;
    logic              l2arb_mem_resp;

    typedef struct packed {
        logic              wr;
        logic              to_d;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } txn_t;

    txn_t sb[$];
    int   checks = 0;
    int   errors = 0;

    l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk                 (clk),
        .reset               (reset),
        .icache_pmem_read    (icache_pmem_read),
        .icache_pmem_address (icache_pmem_address),
        .icache_pmem_rdata   (icache_pmem_rdata),
        .icache_pmem_resp    (icache_pmem_resp),
        .dcache_pmem_read    (dcache_pmem_read),
        .dcache_pmem_write   (dcache_pmem_write),
        .dcache_pmem_address (dcache_pmem_address),
        .dcache_pmem_wdata   (dcache_pmem_wdata),
        .dcache_pmem_rdata   (dcache_pmem_rdata),
        .dcache_pmem_resp    (dcache_pmem_resp),
        .l2arb_mem_read      (l2arb_mem_read),
        .l2arb_mem_write     (l2arb_mem_write),
        .l2arb_mem_address   (l2arb_mem_address),
        .l2arb_mem_wdata     (l2arb_mem_wdata),
        .l2arb_mem_rdata     (l2arb_mem_rdata),
        .l2arb_mem_resp      (l2arb_mem_resp)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic wr, input logic to_d, input logic [ADDR_W-1:0] addr,
                        input logic [LINE_W-1:0] wdata);
        txn_t t;
        t.wr = wr; t.to_d = to_d; t.addr = addr; t.wdata = wdata;
        sb.push_back(t);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        icache_pmem_read = 1'b0; dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0;
        icache_pmem_address = '0; dcache_pmem_address = '0; dcache_pmem_wdata = '0;
        l2arb_mem_rdata = '0; l2arb_mem_resp = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    // Models the L2: waits for the next request, checks it against the scoreboard,
    // answers after lat cycles, then lets the served client drop its request unless keep.
    task automatic serve(input int lat, input logic [LINE_W-1:0] rd, input bit keep);
        txn_t exp;
        int   waited = 0;
        while (!(l2arb_mem_read || l2arb_mem_write) && waited < 20) begin
            step();
            waited++;
        end
        checks++;
        if (!(l2arb_mem_read || l2arb_mem_write)) begin
            errors++;
            $display("FAIL serve_start: no L2 request after %0d cycles, required one", waited);
            return;
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: unexpected L2 request addr=%h, required none", l2arb_mem_address);
            return;
        end
        exp = sb.pop_front();
        checks++;
        if ({l2arb_mem_write, l2arb_mem_read} !== {exp.wr, ~exp.wr}) begin
            errors++;
            $display("FAIL op: write/read=%b%b, required %b%b", l2arb_mem_write, l2arb_mem_read, exp.wr, ~exp.wr);
        end
        checks++;
        if (l2arb_mem_address !== exp.addr) begin
            errors++;
            $display("FAIL address: got %h, required %h", l2arb_mem_address, exp.addr);
        end
        checks++;
        if (l2arb_mem_wdata !== exp.wdata) begin
            errors++;
            $display("FAIL wdata: got %h, required %h", l2arb_mem_wdata, exp.wdata);
        end
        for (int c = 1; c < lat; c++) begin
            step();
            checks++;
            if ({l2arb_mem_write, l2arb_mem_read, l2arb_mem_address, l2arb_mem_wdata} !==
                {exp.wr, ~exp.wr, exp.addr, exp.wdata}) begin
                errors++;
                $display("FAIL hold: cycle %0d wr/rd=%b%b addr=%h, required %b%b addr=%h",
                         c, l2arb_mem_write, l2arb_mem_read, l2arb_mem_address, exp.wr, ~exp.wr, exp.addr);
            end
        end
        l2arb_mem_rdata = rd;
        l2arb_mem_resp  = 1'b1;
        #1;
        checks++;
        if ({dcache_pmem_resp, icache_pmem_resp} !== {exp.to_d, ~exp.to_d}) begin
            errors++;
            $display("FAIL client_resp: d/i resp=%b%b, required %b%b",
                     dcache_pmem_resp, icache_pmem_resp, exp.to_d, ~exp.to_d);
        end
        checks++;
        if ((exp.to_d ? dcache_pmem_rdata : icache_pmem_rdata) !== rd) begin
            errors++;
            $display("FAIL client_rdata: got %h, required %h",
                     exp.to_d ? dcache_pmem_rdata : icache_pmem_rdata, rd);
        end
        step();
        l2arb_mem_resp  = 1'b0;
        l2arb_mem_rdata = '0;
        if (!keep) begin
            if (exp.to_d) begin
                dcache_pmem_read = 1'b0; dcache_pmem_write = 1'b0;
            end else begin
                icache_pmem_read = 1'b0;
            end
        end
        #1;
        checks++;
        if ({l2arb_mem_read, l2arb_mem_write, dcache_pmem_resp, icache_pmem_resp} !== 4'b0000) begin
            errors++;
            $display("FAIL drop: rd/wr/dresp/iresp=%b%b%b%b, required 0000",
                     l2arb_mem_read, l2arb_mem_write, dcache_pmem_resp, icache_pmem_resp);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({l2arb_mem_read, l2arb_mem_write, l2arb_mem_address, l2arb_mem_wdata,
             icache_pmem_resp, dcache_pmem_resp} !== '0) begin
            errors++;
            $display("FAIL reset_state: rd=%b wr=%b addr=%h wdata=%h iresp=%b dresp=%b, required all 0",
                     l2arb_mem_read, l2arb_mem_write, l2arb_mem_address, l2arb_mem_wdata,
                     icache_pmem_resp, dcache_pmem_resp);
        end
    endtask

    task automatic test_icache_read();
        icache_pmem_address = 16'h1230;
        icache_pmem_read    = 1'b1;
        push(1'b0, 1'b0, 16'h1230, '0);
        step();
        checks++;
        if (l2arb_mem_read !== 1'b1) begin
            errors++;
            $display("FAIL i_latency: l2arb_mem_read=%b one edge after request, required 1", l2arb_mem_read);
        end
        serve(3, {16{8'hA5}}, 1'b0);
    endtask

    task automatic test_dcache_write();
        dcache_pmem_address = 16'h4440;
        dcache_pmem_wdata   = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
        dcache_pmem_write   = 1'b1;
        push(1'b1, 1'b1, 16'h4440, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF);
        step();
        serve(2, '0, 1'b1);
        dcache_pmem_address = 16'h4450;
        dcache_pmem_wdata   = 128'hFEED;
        push(1'b1, 1'b1, 16'h4450, 128'hFEED);
        step();
        checks++;
        if (l2arb_mem_write !== 1'b0) begin
            errors++;
            $display("FAIL release_gap: l2arb_mem_write=%b one edge after resp, required 0", l2arb_mem_write);
        end
        step();
        checks++;
        if (l2arb_mem_write !== 1'b1) begin
            errors++;
            $display("FAIL release_resume: l2arb_mem_write=%b two edges after resp, required 1", l2arb_mem_write);
        end
        serve(1, '0, 1'b0);
    endtask

    task automatic test_tie();
        apply_reset();
        dcache_pmem_address = 16'h5550; dcache_pmem_read = 1'b1;
        icache_pmem_address = 16'h6660; icache_pmem_read = 1'b1;
        push(1'b0, 1'b1, 16'h5550, '0);
        push(1'b0, 1'b0, 16'h6660, '0);
        serve(2, 128'h1111, 1'b0);
        serve(2, 128'h2222, 1'b0);
        step();
        dcache_pmem_address = 16'h5560; dcache_pmem_read = 1'b1;
        icache_pmem_address = 16'h6670; icache_pmem_read = 1'b1;
        push(1'b0, 1'b1, 16'h5560, '0);
        serve(2, 128'h3333, 1'b1);
        dcache_pmem_address = 16'h5570;
`ifdef L2ARB_RR_EN
        push(1'b0, 1'b0, 16'h6670, '0);
        push(1'b0, 1'b1, 16'h5570, '0);
`else
        push(1'b0, 1'b1, 16'h5570, '0);
        push(1'b0, 1'b0, 16'h6670, '0);
`endif
        serve(3, 128'h4444, 1'b0);
        serve(1, 128'h5555, 1'b0);
    endtask

    task automatic test_read_write_both();
        step();
        dcache_pmem_address = 16'h2000;
        dcache_pmem_wdata   = 128'hABCD_0000_1234;
        dcache_pmem_read    = 1'b1;
        dcache_pmem_write   = 1'b1;
        push(1'b1, 1'b1, 16'h2000, 128'hABCD_0000_1234);
        serve(2, '0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if ({dcache_pmem_resp, l2arb_mem_write, l2arb_mem_read} !== 3'b000) begin
                errors++;
                $display("FAIL single_resp: cycle %0d dresp/wr/rd=%b%b%b, required 000",
                         c, dcache_pmem_resp, l2arb_mem_write, l2arb_mem_read);
            end
        end
    endtask

    task automatic test_reset_busy();
        icache_pmem_address = 16'h3330;
        icache_pmem_read    = 1'b1;
        step();
        checks++;
        if (l2arb_mem_read !== 1'b1) begin
            errors++;
            $display("FAIL abort_start: l2arb_mem_read=%b, required 1", l2arb_mem_read);
        end
        reset = 1'b1;
        icache_pmem_read = 1'b0;
        step();
        reset = 1'b0;
        checks++;
        if ({l2arb_mem_read, l2arb_mem_write, l2arb_mem_address, icache_pmem_resp, dcache_pmem_resp} !== '0) begin
            errors++;
            $display("FAIL abort_clear: rd=%b wr=%b addr=%h iresp=%b dresp=%b, required all 0",
                     l2arb_mem_read, l2arb_mem_write, l2arb_mem_address, icache_pmem_resp, dcache_pmem_resp);
        end
        l2arb_mem_resp = 1'b1;
        #1;
        checks++;
        if ({icache_pmem_resp, dcache_pmem_resp} !== 2'b00) begin
            errors++;
            $display("FAIL stale_resp: i/d resp=%b%b, required 00", icache_pmem_resp, dcache_pmem_resp);
        end
        step();
        l2arb_mem_resp = 1'b0;
        icache_pmem_address = 16'h3334;
        icache_pmem_read    = 1'b1;
        push(1'b0, 1'b0, 16'h3334, '0);
        serve(2, 128'h7777, 1'b0);
    endtask

    task automatic test_idle_resp();
        step(); step();
        l2arb_mem_rdata = 128'hDEAD;
        l2arb_mem_resp  = 1'b1;
        #1;
        checks++;
        if ({icache_pmem_resp, dcache_pmem_resp} !== 2'b00) begin
            errors++;
            $display("FAIL idle_resp: i/d resp=%b%b, required 00", icache_pmem_resp, dcache_pmem_resp);
        end
        step();
        l2arb_mem_resp  = 1'b0;
        l2arb_mem_rdata = '0;
        checks++;
        if ({l2arb_mem_read, l2arb_mem_write, l2arb_mem_address} !== {2'b00, 16'h3334}) begin
            errors++;
            $display("FAIL idle_outputs: rd=%b wr=%b addr=%h, required rd=0 wr=0 addr=3334",
                     l2arb_mem_read, l2arb_mem_write, l2arb_mem_address);
        end
    endtask

    initial begin
        test_reset();
        test_icache_read();
        test_dcache_write();
        test_tie();
        test_read_write_both();
        test_reset_busy();
        test_idle_resp();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d transactions never seen, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
